lru_2way: RTL and testbench



---
 rtl/lru_2way.sv | 86 ++++++++
 tb/tb_lru_2way.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lru_2way.sv
// Pseudo-LRU replacement tracker for a 2-way set-associative cache.
// Optional per-way hit counters are enabled by defining LRU_HIT_CNT_EN.
module lru_2way #(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned INDEX_W  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               update_en,
  input  logic               hit0,
  input  logic               hit1,
`ifdef LRU_HIT_CNT_EN
  output logic [CNT_W-1:0]   hit0_cnt,
  output logic [CNT_W-1:0]   hit1_cnt,
`endif
  output logic               victim_way
);

  if (NUM_SETS != (1 << INDEX_W)) begin : g_param_chk
    $error("lru_2way: NUM_SETS must equal 2**INDEX_W");
  end

  logic [NUM_SETS-1:0] lru_q;
  logic [NUM_SETS-1:0] lru_d;
  logic                upd0;
  logic                upd1;

  // Simultaneous hits to both ways are illegal and ignored.
  assign upd0 = update_en & hit0 & ~hit1;
  assign upd1 = update_en & hit1 & ~hit0;

  // Each bit names the victim way; touching a way makes the other the victim.
  always_comb begin
    lru_d = lru_q;
    if (upd0) begin
      lru_d[index] = 1'b1;
    end else if (upd1) begin
      lru_d[index] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lru_q <= '0;
    end else begin
      lru_q <= lru_d;
    end
  end

  assign victim_way = lru_q[index];

`ifdef LRU_HIT_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt0_d;
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt1_d;

  // Saturating counters of accepted updates per way.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (upd0 && (cnt0_q != {CNT_W{1'b1}})) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (upd1 && (cnt1_q != {CNT_W{1'b1}})) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign hit0_cnt = cnt0_q;
  assign hit1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_lru_2way.sv
// Scoreboard bench for lru_2way; build with LRU_HIT_CNT_EN to also check the counters.
module tb_lru_2way;

  localparam int unsigned NUM_SETS = 4;
  localparam int unsigned INDEX_W  = 2;
  localparam int unsigned CNT_W    = 2;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               vic;
    logic [CNT_W-1:0]   c0;
    logic [CNT_W-1:0]   c1;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [INDEX_W-1:0] index;
  logic               update_en;
  logic               hit0;
  logic               hit1;
  logic               victim_way;
`ifdef LRU_HIT_CNT_EN
  logic [CNT_W-1:0]   hit0_cnt;
  logic [CNT_W-1:0]   hit1_cnt;
`endif

  exp_t exp_q[$];
  logic obs_vld = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lru_2way #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .update_en  (update_en),
    .hit0       (hit0),
    .hit1       (hit1),
`ifdef LRU_HIT_CNT_EN
    .hit0_cnt   (hit0_cnt),
    .hit1_cnt   (hit1_cnt),
`endif
    .victim_way (victim_way)
  );

  // Drive one cycle's inputs just after the edge; optionally queue an expectation
  // for the state visible during this cycle.
  task automatic cyc(input logic r, input logic [INDEX_W-1:0] idx, input logic ue,
                     input logic h0, input logic h1, input logic chk,
                     input logic ev, input int ec0, input int ec1);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    index     = idx;
    update_en = ue;
    hit0      = h0;
    hit1      = h1;
    obs_vld   = chk;
    if (chk) begin
      e.idx = idx;
      e.vic = ev;
      e.c0  = CNT_W'(ec0);
      e.c1  = CNT_W'(ec1);
      exp_q.push_back(e);
    end
  endtask

  // Read-only probe of a set: no update this cycle.
  task automatic rd(input logic [INDEX_W-1:0] idx, input logic ev, input int ec0, input int ec1);
    cyc(1'b1, idx, 1'b0, 1'b0, 1'b0, 1'b1, ev, ec0, ec1);
  endtask

  // Monitor: compare on the falling edge whenever an observation is flagged.
  always @(negedge clk) begin
    if (obs_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: observation with no expectation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (victim_way !== e.vic) begin
          bad++;
          $display("FAIL victim idx=%0d: got %b want %b", e.idx, victim_way, e.vic);
        end
`ifdef LRU_HIT_CNT_EN
        total++;
        if (hit0_cnt !== e.c0 || hit1_cnt !== e.c1) begin
          bad++;
          $display("FAIL counters idx=%0d: got %0d/%0d want %0d/%0d",
                   e.idx, hit0_cnt, hit1_cnt, e.c0, e.c1);
        end
`endif
      end
    end
  end

  initial begin
    rst = 1'b0; index = '0; update_en = 1'b0; hit0 = 1'b0; hit1 = 1'b0;

    // Reset for two edges, then all sets must report way 0.
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < NUM_SETS; i++) rd(INDEX_W'(i), 1'b0, 0, 0);

    // Way-0 hit on set 0: old value visible during the update cycle.
    cyc(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    rd(2'd0, 1'b1, 1, 0);
    rd(2'd1, 1'b0, 1, 0);
    rd(2'd2, 1'b0, 1, 0);
    rd(2'd3, 1'b0, 1, 0);

    // Way-1 hit on set 1.
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
    rd(2'd1, 1'b0, 1, 1);
    rd(2'd0, 1'b1, 1, 1);
    rd(2'd2, 1'b0, 1, 1);

    // Disabled update, then illegal double hit: nothing changes.
    cyc(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
    cyc(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1);
    rd(2'd2, 1'b0, 1, 1);

    // Back-to-back updates to different sets.
    cyc(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
    cyc(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
    rd(2'd2, 1'b1, 3, 1);
    rd(2'd3, 1'b1, 3, 1);

    // Set 3: way-1 hit, then an idempotent repeat.
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1);
    rd(2'd3, 1'b0, 3, 2);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2);
    rd(2'd3, 1'b0, 3, 3);

    // Reset wins over a simultaneous update.
    cyc(1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3);
    for (int i = 0; i < NUM_SETS; i++) rd(INDEX_W'(i), 1'b0, 0, 0);

    // Five way-0 updates: counter saturates at 2^CNT_W-1 = 3.
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    rd(2'd0, 1'b1, 3, 0);
    rd(2'd1, 1'b0, 3, 0);

    cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
